// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the two-master arbiter and its testbench.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_request(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_arb_starve_mon.sv
// Per-master starvation monitor: saturating stall counter plus a sticky flag
// that software clears; a new crossing of the limit beats a coincident clear.
module ahb_arb_starve_mon #(
  parameter int unsigned STARVE_LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic grant,
  input  logic clear,
  output logic starve
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_q, starve_d;
  logic          set_flag;

  // The flag sets on the cycle the counter steps onto the limit.
  assign set_flag = stall && !grant && (cnt_q == LIMIT - CW'(1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (grant) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (set_flag) begin
      starve_d = 1'b1;
    end else if (clear) begin
      starve_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: non-preemptive handover at transfer boundaries,
// separate address/data-phase ownership, per-master stall steering and starve flags.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned STARVE_LIMIT   = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] S0_HADDR,
  input  logic                  S0_HWRITE,
  input  logic [2:0]            S0_HSIZE,
  input  logic [2:0]            S0_HBURST,
  input  logic [3:0]            S0_HPROT,
  input  logic [1:0]            S0_HTRANS,
  input  logic                  S0_HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] S0_HWDATA,
  output logic                  S0_HREADY,
  output logic                  S0_HRESP,
  output logic [DATA_WIDTH-1:0] S0_HRDATA,
  input  logic [ADDR_WIDTH-1:0] S1_HADDR,
  input  logic                  S1_HWRITE,
  input  logic [2:0]            S1_HSIZE,
  input  logic [2:0]            S1_HBURST,
  input  logic [3:0]            S1_HPROT,
  input  logic [1:0]            S1_HTRANS,
  input  logic                  S1_HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] S1_HWDATA,
  output logic                  S1_HREADY,
  output logic                  S1_HRESP,
  output logic [DATA_WIDTH-1:0] S1_HRDATA,
  output logic                  M_HSEL,
  output logic [ADDR_WIDTH-1:0] M_HADDR,
  output logic                  M_HWRITE,
  output logic [2:0]            M_HSIZE,
  output logic [2:0]            M_HBURST,
  output logic [3:0]            M_HPROT,
  output logic [1:0]            M_HTRANS,
  output logic                  M_HMASTLOCK,
  output logic [DATA_WIDTH-1:0] M_HWDATA,
  input  logic                  M_HREADY,
  input  logic                  M_HRESP,
  input  logic [DATA_WIDTH-1:0] M_HRDATA,
  output logic                  M_HMASTER,
  output logic [1:0]            STARVE,
  input  logic [1:0]            CLR_STARVE
);

  localparam logic DEF_OWNER = 1'(DEFAULT_MASTER);

  logic       addr_owner_q, addr_owner_d;
  logic       data_valid_q, data_valid_d;
  logic       data_owner_q, data_owner_d;
  logic [1:0] req, granted, dphase, stall;
  logic [1:0] hready, hresp;
  logic       owner_yields;

  // Address-phase signals follow the address owner with no added latency.
  assign M_HADDR     = addr_owner_q ? S1_HADDR     : S0_HADDR;
  assign M_HWRITE    = addr_owner_q ? S1_HWRITE    : S0_HWRITE;
  assign M_HSIZE     = addr_owner_q ? S1_HSIZE     : S0_HSIZE;
  assign M_HBURST    = addr_owner_q ? S1_HBURST    : S0_HBURST;
  assign M_HPROT     = addr_owner_q ? S1_HPROT     : S0_HPROT;
  assign M_HTRANS    = addr_owner_q ? S1_HTRANS    : S0_HTRANS;
  assign M_HMASTLOCK = addr_owner_q ? S1_HMASTLOCK : S0_HMASTLOCK;
  assign M_HSEL      = is_request(M_HTRANS);
  assign M_HWDATA    = data_owner_q ? S1_HWDATA : S0_HWDATA;
  assign M_HMASTER   = addr_owner_q;

  assign S0_HRDATA = M_HRDATA;
  assign S1_HRDATA = M_HRDATA;

  assign req     = {is_request(S1_HTRANS), is_request(S0_HTRANS)};
  assign granted = {addr_owner_q, ~addr_owner_q};
  assign dphase  = {data_valid_q & data_owner_q, data_valid_q & ~data_owner_q};
  assign stall   = req & ~granted & ~dphase;

  // Only an unlocked IDLE owner gives up the bus; SEQ/BUSY/NONSEQ never do.
  assign owner_yields = (M_HTRANS == HTRANS_IDLE) && !M_HMASTLOCK;

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_valid_d = data_valid_q;
    data_owner_d = data_owner_q;
    if (M_HREADY) begin
      if (owner_yields && (addr_owner_q ? req[0] : req[1])) begin
        addr_owner_d = ~addr_owner_q;
      end
      data_valid_d = M_HSEL;
      data_owner_d = addr_owner_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q <= DEF_OWNER;
      data_valid_q <= 1'b0;
      data_owner_q <= DEF_OWNER;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_valid_q <= data_valid_d;
      data_owner_q <= data_owner_d;
    end
  end

  // Owners and data-phase holders see the bus response; stalled masters are held.
  always_comb begin
    hready = 2'b11;
    hresp  = {HRESP_OKAY, HRESP_OKAY};
    for (int n = 0; n < 2; n++) begin
      if (granted[n] || dphase[n]) begin
        hready[n] = M_HREADY;
        hresp[n]  = M_HRESP;
      end else begin
        hready[n] = ~stall[n];
      end
    end
  end

  assign S0_HREADY = hready[0];
  assign S0_HRESP  = hresp[0];
  assign S1_HREADY = hready[1];
  assign S1_HRESP  = hresp[1];

  for (genvar n = 0; n < 2; n++) begin : g_starve
    ahb_arb_starve_mon #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_mon (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .stall (stall[n]),
      .grant (granted[n]),
      .clear (CLR_STARVE[n]),
      .starve(STARVE[n])
    );
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules.
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int LIMIT = 4;
  localparam int DEF   = 1;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] s_haddr  [2];
  logic        s_hwrite [2];
  logic [2:0]  s_hsize  [2];
  logic [2:0]  s_hburst [2];
  logic [3:0]  s_hprot  [2];
  logic [1:0]  s_htrans [2];
  logic        s_hlock  [2];
  logic [31:0] s_hwdata [2];
  logic        s_hready [2];
  logic        s_hresp  [2];
  logic [31:0] s_hrdata [2];
  logic        m_hsel, m_hwrite, m_hlock, m_hmaster, m_hready, m_hresp;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [2:0]  m_hsize, m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans, starve, clr_starve;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int own, dow, cnt[2];
  bit dv, stv[2];

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEFAULT_MASTER(DEF), .STARVE_LIMIT(LIMIT)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S0_HADDR(s_haddr[0]), .S0_HWRITE(s_hwrite[0]), .S0_HSIZE(s_hsize[0]),
    .S0_HBURST(s_hburst[0]), .S0_HPROT(s_hprot[0]), .S0_HTRANS(s_htrans[0]),
    .S0_HMASTLOCK(s_hlock[0]), .S0_HWDATA(s_hwdata[0]), .S0_HREADY(s_hready[0]),
    .S0_HRESP(s_hresp[0]), .S0_HRDATA(s_hrdata[0]),
    .S1_HADDR(s_haddr[1]), .S1_HWRITE(s_hwrite[1]), .S1_HSIZE(s_hsize[1]),
    .S1_HBURST(s_hburst[1]), .S1_HPROT(s_hprot[1]), .S1_HTRANS(s_htrans[1]),
    .S1_HMASTLOCK(s_hlock[1]), .S1_HWDATA(s_hwdata[1]), .S1_HREADY(s_hready[1]),
    .S1_HRESP(s_hresp[1]), .S1_HRDATA(s_hrdata[1]),
    .M_HSEL(m_hsel), .M_HADDR(m_haddr), .M_HWRITE(m_hwrite), .M_HSIZE(m_hsize),
    .M_HBURST(m_hburst), .M_HPROT(m_hprot), .M_HTRANS(m_htrans),
    .M_HMASTLOCK(m_hlock), .M_HWDATA(m_hwdata), .M_HREADY(m_hready),
    .M_HRESP(m_hresp), .M_HRDATA(m_hrdata), .M_HMASTER(m_hmaster),
    .STARVE(starve), .CLR_STARVE(clr_starve)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = DEF; dow = DEF; dv = 1'b0;
    for (int n = 0; n < 2; n++) begin
      cnt[n] = 0;
      stv[n] = 1'b0;
    end
  endtask

  // Expected outputs follow directly from the current model state and inputs.
  task automatic check_outputs(input string tag);
    int  o;
    logic er, ep;
    o = own;
    check({tag, " hmaster"}, 64'(m_hmaster), 64'(o));
    check({tag, " haddr"},   64'(m_haddr),   64'(s_haddr[o]));
    check({tag, " htrans"},  64'(m_htrans),  64'(s_htrans[o]));
    check({tag, " hsel"},    64'(m_hsel),    64'(s_htrans[o][1]));
    check({tag, " hwrite"},  64'(m_hwrite),  64'(s_hwrite[o]));
    check({tag, " hsize"},   64'(m_hsize),   64'(s_hsize[o]));
    check({tag, " hburst"},  64'(m_hburst),  64'(s_hburst[o]));
    check({tag, " hprot"},   64'(m_hprot),   64'(s_hprot[o]));
    check({tag, " hlock"},   64'(m_hlock),   64'(s_hlock[o]));
    check({tag, " hwdata"},  64'(m_hwdata),  64'(s_hwdata[dow]));
    check({tag, " starve"},  64'(starve),    64'({stv[1], stv[0]}));
    for (int n = 0; n < 2; n++) begin
      if (own == n || (dv && dow == n)) begin
        er = m_hready; ep = m_hresp;
      end else if (s_htrans[n][1]) begin
        er = 1'b0; ep = 1'b0;
      end else begin
        er = 1'b1; ep = 1'b0;
      end
      check($sformatf("%s s%0d_hready", tag, n), 64'(s_hready[n]), 64'(er));
      check($sformatf("%s s%0d_hresp", tag, n),  64'(s_hresp[n]),  64'(ep));
      check($sformatf("%s s%0d_hrdata", tag, n), 64'(s_hrdata[n]), 64'(m_hrdata));
    end
  endtask

  task automatic model_edge();
    bit st[2];
    bit set_now;
    int new_own;
    new_own = own;
    for (int n = 0; n < 2; n++)
      st[n] = (own != n) && !(dv && dow == n) && s_htrans[n][1];
    if (m_hready) begin
      if (s_htrans[own] == HTRANS_IDLE && !s_hlock[own] && s_htrans[1-own][1])
        new_own = 1 - own;
      dv  = s_htrans[own][1];
      dow = own;
    end
    for (int n = 0; n < 2; n++) begin
      set_now = 1'b0;
      if (own == n) cnt[n] = 0;
      else if (st[n] && cnt[n] < LIMIT) begin
        cnt[n]++;
        set_now = (cnt[n] == LIMIT);
      end
      if (set_now) stv[n] = 1'b1;
      else if (clr_starve[n]) stv[n] = 1'b0;
    end
    own = new_own;
  endtask

  task automatic tick(input string tag);
    @(negedge HCLK);
    check_outputs(tag);
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  task automatic drive(input int n, input logic [1:0] trans, input logic [31:0] addr,
                       input logic write, input logic lock);
    s_htrans[n] = trans;
    s_haddr[n]  = addr;
    s_hwrite[n] = write;
    s_hlock[n]  = lock;
    s_hwdata[n] = $urandom();
    s_hsize[n]  = 3'd2;
    s_hprot[n]  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    HRESETn = 1'b0;
    for (int n = 0; n < 2; n++) begin
      drive(n, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
      s_hburst[n] = HBURST_SINGLE;
    end
    m_hready = 1'b1; m_hresp = 1'b0; m_hrdata = 32'h1234_5678; clr_starve = 2'b00;
    model_reset();
    #12;
    check("reset hmaster", 64'(m_hmaster), 64'(1));
    check("reset s0_hready", 64'(s_hready[0]), 64'(1));
    check("reset s1_hready", 64'(s_hready[1]), 64'(1));
    check("reset starve", 64'(starve), 64'(0));
    check_outputs("reset");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // master 0 single write while master 1 is parked idle
    drive(0, HTRANS_NONSEQ, 32'h100, 1'b1, 1'b0);
    #1;
    check("s2 handover stall", 64'(s_hready[0]), 64'(0));
    check("s2 handover idle", 64'(m_htrans), 64'(HTRANS_IDLE));
    tick("s2 yield");
    check("s2 hmaster", 64'(m_hmaster), 64'(0));
    check("s2 haddr", 64'(m_haddr), 64'(32'h100));
    check("s2 htrans", 64'(m_htrans), 64'(HTRANS_NONSEQ));
    tick("s2 addr");
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    s_hwdata[0] = 32'hCAFE_0100;
    #1;
    check("s2 hwdata", 64'(m_hwdata), 64'(32'hCAFE_0100));
    tick("s2 data");

    // master 1 INCR4 burst with master 0 requesting mid-burst
    s_hburst[1] = HBURST_INCR4;
    drive(1, HTRANS_NONSEQ, 32'h200, 1'b1, 1'b0);
    tick("s3 yield");
    check("s3 hmaster", 64'(m_hmaster), 64'(1));
    drive(0, HTRANS_NONSEQ, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      #1;
      check($sformatf("s3 beat%0d s0_hready", i), 64'(s_hready[0]), 64'(0));
      check($sformatf("s3 beat%0d haddr", i), 64'(m_haddr), 64'(32'h200 + 32'(4 * i)));
      tick("s3 beat");
    end
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    #1;
    check("s3 idle hmaster", 64'(m_hmaster), 64'(1));
    check("s3 idle s0_hready", 64'(s_hready[0]), 64'(0));
    tick("s3 idle");
    check("s3 new owner", 64'(m_hmaster), 64'(0));
    check("s3 new haddr", 64'(m_haddr), 64'(32'h300));
    tick("s3 addr");

    // master 1 locked while idle: no handover
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'h400, 1'b0, 1'b1);
    tick("s4 yield");
    check("s4 hmaster", 64'(m_hmaster), 64'(1));
    drive(0, HTRANS_NONSEQ, 32'h500, 1'b0, 1'b0);
    tick("s4 addr");
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("s4 lock%0d hmaster", i), 64'(m_hmaster), 64'(1));
      check($sformatf("s4 lock%0d s0_hready", i), 64'(s_hready[0]), 64'(0));
      tick("s4 lock");
    end
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    tick("s4 unlock");
    check("s4 new owner", 64'(m_hmaster), 64'(0));
    check("s4 new haddr", 64'(m_haddr), 64'(32'h500));
    tick("s5 addr");

    // two wait states then a two-cycle ERROR on master 0's read
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'h600, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m_hready = (i == 3);
      m_hresp  = (i >= 2);
      #1;
      check($sformatf("s5 cyc%0d hmaster", i), 64'(m_hmaster), 64'(0));
      check($sformatf("s5 cyc%0d s0_hresp", i), 64'(s_hresp[0]), 64'(i >= 2));
      check($sformatf("s5 cyc%0d s0_hready", i), 64'(s_hready[0]), 64'(i == 3));
      check($sformatf("s5 cyc%0d s1_hresp", i), 64'(s_hresp[1]), 64'(0));
      tick("s5 resp");
    end
    m_hready = 1'b1; m_hresp = 1'b0;
    check("s5 handover", 64'(m_hmaster), 64'(1));

    // starvation: master 1 streams NONSEQ, master 0 waits
    drive(0, HTRANS_NONSEQ, 32'h700, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      clr_starve = (i == 0) ? 2'b11 : (i == 3) ? 2'b01 : 2'b00;
      drive(1, HTRANS_NONSEQ, 32'h600 + 32'(16 * i), 1'b1, 1'b0);
      tick("s6 stall");
      check($sformatf("s6 stall%0d starve0", i), 64'(starve[0]), 64'(i == 3));
    end
    clr_starve = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drive(1, HTRANS_NONSEQ, 32'h680 + 32'(16 * i), 1'b1, 1'b0);
      tick("s6 sticky");
      check("s6 sticky starve0", 64'(starve[0]), 64'(1));
    end
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    tick("s6 yield");
    check("s6 granted", 64'(m_hmaster), 64'(0));
    clr_starve = 2'b01;
    tick("s6 clear");
    check("s6 cleared starve0", 64'(starve[0]), 64'(0));
    clr_starve = 2'b00;
    drive(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    tick("s6 done");

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        s_htrans[n] = 2'($urandom_range(0, 3));
        s_haddr[n]  = $urandom();
        s_hwdata[n] = $urandom();
        s_hwrite[n] = 1'($urandom_range(0, 1));
        s_hsize[n]  = 3'($urandom_range(0, 2));
        s_hburst[n] = 3'($urandom_range(0, 7));
        s_hprot[n]  = 4'($urandom_range(0, 15));
        s_hlock[n]  = ($urandom_range(0, 7) == 0);
      end
      m_hready   = ($urandom_range(0, 3) != 0);
      m_hresp    = ($urandom_range(0, 9) == 0);
      m_hrdata   = $urandom();
      clr_starve = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick("rand");
    end

    // asynchronous reset in the middle of a cycle
    drive(0, HTRANS_NONSEQ, 32'h800, 1'b1, 1'b0);
    drive(1, HTRANS_NONSEQ, 32'h900, 1'b0, 1'b0);
    m_hready = 1'b1; m_hresp = 1'b0; clr_starve = 2'b00;
    @(negedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    check("midrst hmaster", 64'(m_hmaster), 64'(1));
    check("midrst haddr", 64'(m_haddr), 64'(32'h900));
    check("midrst starve", 64'(starve), 64'(0));
    model_reset();
    check_outputs("midrst");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    drive(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("post rst");
    check("post rst owner", 64'(m_hmaster), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
